// File: rtl/sd_sector_server.sv
// rtl/sd_sector_server.sv - serves 512-byte sector reads/writes for four drive images stored on an SD card
// Arbitrates per-drive requests, maps them to absolute LBAs and streams bytes between the SD core and the requester buffer.
module sd_sector_server #(
    parameter logic [31:0] IMG_BASE    = 32'd0,
    parameter logic [31:0] IMG_SECTORS = 32'd1600,
    parameter int          TMO_W       = 24
) (
    input  logic        pin_25mhz_ck,
    input  logic        rst_n_i,
    input  logic [3:0]  rstart,
    input  logic [3:0]  wstart,
    input  logic [31:0] rsector,
    output logic        rbusy,
    output logic        rdone,
    output logic        rerr,
    output logic        outen,
    output logic [8:0]  outaddr,
    output logic [7:0]  inbyte,
    input  logic [7:0]  outbyte,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic [31:0] sd_lba,
    input  logic        sd_busy,
    input  logic        sd_rd_valid,
    input  logic [7:0]  sd_rd_byte,
    input  logic        sd_wr_req,
    input  logic        sd_err,
    output logic [7:0]  sd_wr_byte
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_RD_XFER = 3'd2;
    localparam logic [2:0] S_WR_PRE  = 3'd3;
    localparam logic [2:0] S_WR_XFER = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [9:0]       FULL     = 10'd512;
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

    logic [2:0]       state_q, state_d;
    logic             dir_q, dir_d;
    logic [9:0]       count_q, count_d;
    logic             seen_busy_q, seen_busy_d;
    logic             err_seen_q, err_seen_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             pre_q, pre_d;
    logic [1:0]       fetch_q, fetch_d;
    logic             rbusy_q, rbusy_d;
    logic             rdone_q, rdone_d;
    logic             rerr_q, rerr_d;
    logic             outen_q, outen_d;
    logic [8:0]       outaddr_q, outaddr_d;
    logic [7:0]       inbyte_q, inbyte_d;
    logic             sd_rd_q, sd_rd_d;
    logic             sd_wr_q, sd_wr_d;
    logic [31:0]      sd_lba_q, sd_lba_d;
    logic [7:0]       sd_wr_byte_q, sd_wr_byte_d;

    logic [3:0]  req_any;
    logic [1:0]  sel;
    logic        sel_wr;
    logic [31:0] lba_calc;

    assign req_any = rstart | wstart;

    // Lowest drive index wins; within a drive a write beats a read.
    always_comb begin
        sel    = 2'd0;
        sel_wr = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (req_any[i]) begin
                sel    = 2'(i);
                sel_wr = wstart[i];
            end
        end
    end

    assign lba_calc = IMG_BASE + (32'(sel) * IMG_SECTORS) + rsector;

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        count_d      = count_q;
        seen_busy_d  = seen_busy_q;
        err_seen_d   = err_seen_q;
        tmo_d        = tmo_q;
        pre_d        = pre_q;
        fetch_d      = {fetch_q[0], 1'b0};
        rbusy_d      = rbusy_q;
        rdone_d      = 1'b0;
        rerr_d       = rerr_q;
        outen_d      = 1'b0;
        outaddr_d    = outaddr_q;
        inbyte_d     = inbyte_q;
        sd_rd_d      = 1'b0;
        sd_wr_d      = 1'b0;
        sd_lba_d     = sd_lba_q;
        sd_wr_byte_d = sd_wr_byte_q;

        case (state_q)
            S_IDLE: begin
                // Holding off while rdone is high spaces re-accepts two cycles after completion.
                if ((|req_any) && !rdone_q) begin
                    dir_d       = sel_wr;
                    sd_lba_d    = lba_calc;
                    rbusy_d     = 1'b1;
                    rerr_d      = 1'b0;
                    count_d     = 10'd0;
                    seen_busy_d = 1'b0;
                    err_seen_d  = 1'b0;
                    tmo_d       = '0;
                    if (rsector >= IMG_SECTORS) begin
                        rerr_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                tmo_d = tmo_q + TMO_ONE;
                if (tmo_q == TMO_MAX) begin
                    rerr_d  = 1'b1;
                    state_d = S_DONE;
                end else if (!sd_busy) begin
                    tmo_d = '0;
                    if (dir_q) begin
                        outaddr_d = 9'd0;
                        pre_d     = 1'b0;
                        state_d   = S_WR_PRE;
                    end else begin
                        sd_rd_d = 1'b1;
                        state_d = S_RD_XFER;
                    end
                end
            end

            S_RD_XFER: begin
                if (sd_busy) seen_busy_d = 1'b1;
                if (sd_err) err_seen_d = 1'b1;
                tmo_d = tmo_q + TMO_ONE;
                if (sd_rd_valid) begin
                    tmo_d = '0;
                    if (count_q != FULL) begin
                        outen_d   = 1'b1;
                        outaddr_d = count_q[8:0];
                        inbyte_d  = sd_rd_byte;
                        count_d   = count_q + 10'd1;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    rerr_d  = 1'b1;
                    state_d = S_DONE;
                end else if (seen_busy_q && !sd_busy) begin
                    rerr_d  = (count_q != FULL) || err_seen_q || sd_err;
                    state_d = S_DONE;
                end
            end

            S_WR_PRE: begin
                // First cycle presents address 0; the buffer answers one cycle later.
                if (!pre_q) begin
                    pre_d = 1'b1;
                end else begin
                    sd_wr_byte_d = outbyte;
                    sd_wr_d      = 1'b1;
                    count_d      = 10'd0;
                    seen_busy_d  = 1'b0;
                    tmo_d        = '0;
                    state_d      = S_WR_XFER;
                end
            end

            S_WR_XFER: begin
                if (sd_busy) seen_busy_d = 1'b1;
                if (sd_err) err_seen_d = 1'b1;
                tmo_d = tmo_q + TMO_ONE;
                if (fetch_q[1]) sd_wr_byte_d = outbyte;
                if (sd_wr_req) begin
                    tmo_d = '0;
                    if (count_q != FULL) count_d = count_q + 10'd1;
                    if (count_q >= 10'd511) begin
                        sd_wr_byte_d = 8'h00;
                    end else begin
                        outaddr_d  = count_q[8:0] + 9'd1;
                        fetch_d[0] = 1'b1;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    rerr_d  = 1'b1;
                    state_d = S_DONE;
                end else if (seen_busy_q && !sd_busy) begin
                    rerr_d  = (count_q != FULL) || err_seen_q || sd_err;
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                rdone_d = 1'b1;
                rbusy_d = 1'b0;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pin_25mhz_ck or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            dir_q        <= 1'b0;
            count_q      <= 10'd0;
            seen_busy_q  <= 1'b0;
            err_seen_q   <= 1'b0;
            tmo_q        <= '0;
            pre_q        <= 1'b0;
            fetch_q      <= 2'b00;
            rbusy_q      <= 1'b0;
            rdone_q      <= 1'b0;
            rerr_q       <= 1'b0;
            outen_q      <= 1'b0;
            outaddr_q    <= 9'd0;
            inbyte_q     <= 8'd0;
            sd_rd_q      <= 1'b0;
            sd_wr_q      <= 1'b0;
            sd_lba_q     <= 32'd0;
            sd_wr_byte_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            count_q      <= count_d;
            seen_busy_q  <= seen_busy_d;
            err_seen_q   <= err_seen_d;
            tmo_q        <= tmo_d;
            pre_q        <= pre_d;
            fetch_q      <= fetch_d;
            rbusy_q      <= rbusy_d;
            rdone_q      <= rdone_d;
            rerr_q       <= rerr_d;
            outen_q      <= outen_d;
            outaddr_q    <= outaddr_d;
            inbyte_q     <= inbyte_d;
            sd_rd_q      <= sd_rd_d;
            sd_wr_q      <= sd_wr_d;
            sd_lba_q     <= sd_lba_d;
            sd_wr_byte_q <= sd_wr_byte_d;
        end
    end

    assign rbusy      = rbusy_q;
    assign rdone      = rdone_q;
    assign rerr       = rerr_q;
    assign outen      = outen_q;
    assign outaddr    = outaddr_q;
    assign inbyte     = inbyte_q;
    assign sd_rd      = sd_rd_q;
    assign sd_wr      = sd_wr_q;
    assign sd_lba     = sd_lba_q;
    assign sd_wr_byte = sd_wr_byte_q;

endmodule

// File: tb/tb_sd_sector_server.sv
// tb/tb_sd_sector_server.sv - scoreboard bench for sd_sector_server
// Stimulus pushes expected strobes/commands/completions; a negedge monitor pops and compares.
module tb_sd_sector_server;

    logic        clk = 1'b0;
    logic        rst_n_i;
    logic [3:0]  rstart, wstart;
    logic [31:0] rsector;
    logic        rbusy, rdone, rerr, outen;
    logic [8:0]  outaddr;
    logic [7:0]  inbyte, outbyte;
    logic        sd_rd, sd_wr;
    logic [31:0] sd_lba;
    logic        sd_busy, sd_rd_valid, sd_wr_req, sd_err;
    logic [7:0]  sd_rd_byte, sd_wr_byte;

    logic [7:0]  buf_mem [512];
    logic [63:0] q_outen[$];
    logic [63:0] q_wrb[$];
    logic [63:0] q_cmd[$];
    logic [63:0] q_done[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sd_sector_server #(.TMO_W(10)) dut (
        .pin_25mhz_ck(clk), .rst_n_i(rst_n_i),
        .rstart(rstart), .wstart(wstart), .rsector(rsector),
        .rbusy(rbusy), .rdone(rdone), .rerr(rerr),
        .outen(outen), .outaddr(outaddr), .inbyte(inbyte), .outbyte(outbyte),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba),
        .sd_busy(sd_busy), .sd_rd_valid(sd_rd_valid), .sd_rd_byte(sd_rd_byte),
        .sd_wr_req(sd_wr_req), .sd_err(sd_err), .sd_wr_byte(sd_wr_byte)
    );

    // Requester sector buffer with one-cycle read latency.
    always @(posedge clk) outbyte <= buf_mem[outaddr];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event, value %0h", nm, act);
    endtask

    always @(negedge clk) begin
        if (rst_n_i) begin
            if (outen) begin
                if (q_outen.size() == 0) flag("outen", {outaddr, inbyte});
                else chk("outen", 64'({outaddr, inbyte}), q_outen.pop_front());
            end
            if (sd_wr_req) begin
                if (q_wrb.size() == 0) flag("wr_byte", 64'(sd_wr_byte));
                else chk("wr_byte", 64'(sd_wr_byte), q_wrb.pop_front());
            end
            if (sd_rd || sd_wr) begin
                if (sd_rd && sd_wr) flag("rd_wr_both", 64'd3);
                else if (q_cmd.size() == 0) flag("cmd", {sd_wr, sd_lba});
                else chk("cmd", 64'({sd_wr, sd_lba}), q_cmd.pop_front());
            end
            if (rdone) begin
                if (q_done.size() == 0) flag("rdone", {rbusy, rerr});
                else chk("rdone_rbusy_rerr", 64'({rbusy, rerr}), q_done.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return rbusy;
            1: return sd_rd;
            2: return sd_wr;
            default: return rdone;
        endcase
    endfunction

    task automatic wait_sig(input int w, input int lim, input string nm, output int n);
        n = 0;
        while (!sig(w) && n < lim) begin
            tick();
            n++;
        end
        chk(nm, 64'(sig(w)), 64'd1);
    endtask

    task automatic outputs_zero(input string nm);
        chk(nm, 64'({rbusy, rdone, rerr, outen, sd_rd, sd_wr, outaddr, inbyte, sd_wr_byte}), 64'd0);
        chk({nm, "_lba"}, 64'(sd_lba), 64'd0);
    endtask

    task automatic request(input logic [3:0] rs, input logic [3:0] ws, input logic [31:0] sec);
        int n;
        rsector = sec;
        rstart  = rs;
        wstart  = ws;
        wait_sig(0, 20, "accept_wait", n);
        rstart = 4'd0;
        wstart = 4'd0;
    endtask

    task automatic respond_read(input int nbytes, input logic errp);
        int n;
        wait_sig(1, 20, "sd_rd_wait", n);
        tick();
        sd_busy = 1'b1;
        tick();
        tick();
        for (int i = 0; i < nbytes; i++) begin
            sd_rd_valid = 1'b1;
            sd_rd_byte  = 8'(i);
            if (i < 512) q_outen.push_back(64'({9'(i), 8'(i)}));
            tick();
        end
        sd_rd_valid = 1'b0;
        sd_err = errp;
        tick();
        sd_err  = 1'b0;
        sd_busy = 1'b0;
        wait_sig(3, 20, "rdone_wait", n);
        tick();
    endtask

    initial begin
        int n;
        rst_n_i = 1'b0;
        rstart = 4'd0; wstart = 4'd0; rsector = 32'd0;
        sd_busy = 1'b0; sd_rd_valid = 1'b0; sd_rd_byte = 8'd0;
        sd_wr_req = 1'b0; sd_err = 1'b0;
        for (int i = 0; i < 512; i++) buf_mem[i] = 8'((i * 7) + 3);
        tick(); tick();
        outputs_zero("reset_state");
        rst_n_i = 1'b1;
        tick();

        // Plain read, drive 0 sector 5.
        q_cmd.push_back({31'd0, 1'b0, 32'd5});
        q_done.push_back(64'd0);
        request(4'b0001, 4'b0000, 32'd5);
        respond_read(512, 1'b0);

        // Drive 1 write beats drive 2 read; drive 2 then re-served with the changed sector.
        q_cmd.push_back({31'd0, 1'b1, 32'd1607});
        q_cmd.push_back({31'd0, 1'b0, 32'd3299});
        q_done.push_back(64'd0);
        rsector = 32'd7;
        rstart  = 4'b0100;
        wstart  = 4'b0010;
        wait_sig(0, 20, "wr_accept_wait", n);
        wstart  = 4'd0;
        rsector = 32'd99;
        wait_sig(2, 20, "sd_wr_wait", n);
        tick();
        sd_busy = 1'b1;
        tick();
        for (int i = 0; i < 513; i++) begin
            q_wrb.push_back(64'((i < 512) ? buf_mem[i] : 8'h00));
            sd_wr_req = 1'b1;
            tick();
            sd_wr_req = 1'b0;
            tick(); tick(); tick();
        end
        sd_busy = 1'b0;
        wait_sig(3, 20, "wr_rdone_wait", n);
        q_done.push_back(64'd0);
        n = 0;
        while (!rbusy && n < 10) begin
            tick();
            n++;
        end
        chk("reaccept_gap_ok", 64'(n >= 2 && n <= 4), 64'd1);
        rstart = 4'd0;
        respond_read(512, 1'b0);

        // Out-of-range sector on drive 3: error without SD command.
        q_done.push_back(64'd1);
        rsector = 32'd1600;
        rstart  = 4'b1000;
        n = 0;
        while (!rdone && n < 10) begin
            tick();
            n++;
            if (rbusy) rstart = 4'd0;
        end
        chk("range_err_latency_ok", 64'(n <= 3), 64'd1);
        rstart = 4'd0;
        tick();
        chk("rerr_held", 64'(rerr), 64'd1);
        tick();

        // Short transfer: busy drops after 300 bytes.
        q_cmd.push_back({31'd0, 1'b0, 32'd10});
        q_done.push_back(64'd1);
        request(4'b0001, 4'b0000, 32'd10);
        respond_read(300, 1'b0);

        // Full transfer but SD core reports an error.
        q_cmd.push_back({31'd0, 1'b0, 32'd3200});
        q_done.push_back(64'd1);
        request(4'b0100, 4'b0000, 32'd0);
        respond_read(512, 1'b1);

        // Reset at byte 100 of a drive-3 read of the last valid sector.
        q_cmd.push_back({31'd0, 1'b0, 32'd6399});
        rsector = 32'd1599;
        rstart  = 4'b1000;
        wait_sig(0, 20, "rst_accept_wait", n);
        wait_sig(1, 20, "rst_sd_rd_wait", n);
        tick();
        sd_busy = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) begin
            sd_rd_valid = 1'b1;
            sd_rd_byte  = 8'(i);
            q_outen.push_back(64'({9'(i), 8'(i)}));
            tick();
        end
        sd_rd_valid = 1'b0;
        @(negedge clk);
        #1 rst_n_i = 1'b0;
        #1;
        outputs_zero("async_reset");
        sd_busy = 1'b0;
        tick(); tick(); tick();
        chk("no_rdone_in_reset", 64'(rdone), 64'd0);
        q_cmd.push_back({31'd0, 1'b0, 32'd6399});
        q_done.push_back(64'd0);
        rst_n_i = 1'b1;
        wait_sig(0, 20, "rearb_accept_wait", n);
        rstart = 4'd0;
        respond_read(512, 1'b0);

        // Silent SD core: timeout after 2^TMO_W-1 idle cycles.
        q_cmd.push_back({31'd0, 1'b0, 32'd0});
        q_done.push_back(64'd1);
        request(4'b0001, 4'b0000, 32'd0);
        wait_sig(1, 20, "tmo_sd_rd_wait", n);
        wait_sig(3, 1100, "tmo_rdone_wait", n);
        chk("timeout_window_ok", 64'(n >= 1023 && n <= 1027), 64'd1);
        tick(); tick();

        chk("outen_queue_empty", 64'(q_outen.size()), 64'd0);
        chk("wrb_queue_empty", 64'(q_wrb.size()), 64'd0);
        chk("cmd_queue_empty", 64'(q_cmd.size()), 64'd0);
        chk("done_queue_empty", 64'(q_done.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/sd_sector_server.md
SD_SECTOR_SERVER -- requirements
Module: sd_sector_server

Interface
REQ-001 Parameter IMG_BASE, default 32'd0, meaning SD LBA of drive-0 image start.
REQ-002 Parameter IMG_SECTORS, default 1600, meaning sectors per drive image (819200/512).
REQ-003 pin_25mhz_ck  in  1  sole clock, all state on rising edge.
REQ-004 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 rstart  in  4  per-drive read request, level, held by requester until rbusy seen.
REQ-006 wstart  in  4  per-drive write request, same rules as rstart.
REQ-007 rsector  in  32  sector index within selected drive image.
REQ-008 rbusy  out  1  high from request accept until rdone.
REQ-009 rdone  out  1  one-cycle completion pulse.
REQ-010 rerr  out  1  error flag for last transfer, valid with rdone, held until next accept.
REQ-011 outen  out  1  one-cycle write strobe into requester sector buffer.
REQ-012 outaddr  out  9  requester buffer byte address 0..511.
REQ-013 inbyte  out  8  byte written to requester buffer when outen=1.
REQ-014 outbyte  in  8  requester buffer read data, valid one cycle after outaddr with outen=0.
REQ-015 sd_rd / sd_wr  out  1 each  one-cycle command pulses to SD core.
REQ-016 sd_lba  out  32  absolute LBA, stable from command pulse until rdone.
REQ-017 sd_busy  in  1  SD core busy; sd_rd_valid  in  1; sd_rd_byte  in  8; sd_wr_req  in  1; sd_err  in  1.
REQ-018 sd_wr_byte  out  8  byte consumed by SD core on sd_wr_req.

Function
REQ-019 States: IDLE, ISSUE, RD_XFER, WR_PRE, WR_XFER, DONE.
REQ-020 IDLE: accept when any rstart|wstart bit set; lowest drive index wins; for same index wstart beats rstart.
REQ-021 On accept: latch drive index, direction, rsector; rbusy=1 next cycle; rerr cleared.
REQ-022 sd_lba = IMG_BASE + drive*IMG_SECTORS + rsector, 32-bit, wrap-around on overflow (no saturation).
REQ-023 rsector >= IMG_SECTORS: no SD command, go DONE with rerr=1.
REQ-024 ISSUE: wait for sd_busy=0, then pulse sd_rd (read) and enter RD_XFER, or enter WR_PRE (write).
REQ-025 RD_XFER: each sd_rd_valid, next cycle outen=1, outaddr=byte count, inbyte=sd_rd_byte; count +1.
REQ-026 Bytes beyond 512 ignored, no outen; count saturates at 512.
REQ-027 RD_XFER exits to DONE when sd_busy=0 after command accepted (sd_busy seen high at least once); count!=512 or sd_err -> rerr=1.
REQ-028 WR_PRE: drive outaddr=0, outen=0, capture outbyte after one cycle into sd_wr_byte, then pulse sd_wr, enter WR_XFER.
REQ-029 WR_XFER: on sd_wr_req, advance outaddr, load next outbyte into sd_wr_byte within 2 cycles; SD core guarantees >=3 cycles between sd_wr_req.
REQ-030 WR_XFER exits as REQ-027; requests beyond 512 get sd_wr_byte=8'h00.
REQ-031 Timeout: 24-bit counter, cleared on any sd_rd_valid/sd_wr_req; reaching 0xFFFFFF in ISSUE/RD_XFER/WR_XFER -> DONE, rerr=1.
REQ-032 DONE: rdone=1 one cycle, rbusy=0 same cycle, return IDLE; request still held -> re-accept no earlier than 2 cycles after rdone.
REQ-033 outen never asserted outside RD_XFER; sd_rd and sd_wr never both high.
REQ-034 Request bits changing after accept have no effect on current transfer.

Reset
REQ-035 rst_n_i=0 asynchronously forces IDLE and rbusy, rdone, rerr, outen, sd_rd, sd_wr=0, outaddr=0, inbyte=0, sd_wr_byte=0, sd_lba=0, counters=0.
REQ-036 Reset mid-transfer aborts without rdone; after release, pending requests are re-arbitrated from IDLE.

Verification
REQ-037 rstart=4'b0001, rsector=5, 512 sd_rd_valid bytes 0..255 repeating -> sd_lba=5, outen x512 addr 0..511, rdone, rerr=0.
REQ-038 rstart=4'b0100, wstart=4'b0010 same cycle -> drive 1 write first, sd_lba=1600+rsector, sd_wr pulse, 512 bytes from outbyte in order.
REQ-039 rstart=4'b1000, rsector=1600 -> no sd_rd, rdone with rerr=1 within 3 cycles.
REQ-040 Read with sd_busy dropping after 300 bytes -> 300 outen strobes, rdone, rerr=1.
REQ-041 rst_n_i low at byte 100 of read -> all outputs 0 immediately, no rdone; held rstart re-served after release.
REQ-042 SD core silent after sd_rd -> rdone with rerr=1 after 2^24-1 idle cycles.
